conv3x3_stream: RTL
===================

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 Parameter WIDTH, default 256, frame width in pixels (>=3).
REQ-002 Parameter HEIGHT, default 256, frame height in lines (>=3).
REQ-003 Parameter BITW, default 8, input pixel width, unsigned.
REQ-004 Parameter ACCW, default 20, signed accumulator width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 k_flat  input  72  nine signed 8-bit coefficients; k00 in [7:0], k01 in [15:8], and so on row-major to k22 in [71:64].
REQ-008 shift  input  4  arithmetic right-shift applied to the accumulator before saturation.
REQ-009 mode  input  1  0 = signed clamp, 1 = absolute value then clamp.
REQ-010 in_valid  input  1  in_pixel valid.
REQ-011 in_ready  output  1  block accepts in_pixel this cycle.
REQ-012 in_pixel  input  BITW  raster-order pixel, row 0 col 0 first.
REQ-013 out_valid  output  1  out_pixel valid.
REQ-014 out_ready  input  1  downstream accepts out_pixel.
REQ-015 out_pixel  output  8  result pixel.
REQ-016 out_last  output  1  high with the final output pixel (row HEIGHT-1, col WIDTH-1) of a frame.
REQ-017 frame_done  output  1  one-cycle pulse on the cycle after the out_last transfer.

Function
REQ-018 An input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-019 The block SHALL emit exactly WIDTH*HEIGHT output pixels per frame, in raster order, one per input pixel.
REQ-020 Border outputs (row 0, row HEIGHT-1, col 0, col WIDTH-1) SHALL be 0.
REQ-021 Interior output (r,c): acc = sum over i,j of k_ij * u_ij, with u_ij = pixel(r-1+i, c-1+j); products are sign-extended to ACCW; no internal overflow for the defaults.
REQ-022 res = acc >>> shift; mode 0: res<0 -> 0, res>255 -> 255, else res; mode 1: |res| with values >255 set to 255.
REQ-023 Two line buffers of WIDTH x BITW and a 3x3 window register SHALL hold the neighbourhood; no frame store is permitted.
REQ-024 k_flat, shift and mode SHALL be latched on the first input transfer of a frame (row 0, col 0) and held for the whole frame.
REQ-025 Output index o (o = r*WIDTH + c) becomes eligible once input index o+WIDTH+1 has been accepted, or once all inputs of the frame have been accepted.
REQ-026 Eligible outputs SHALL be presented through a single output register; out_valid rises the cycle after eligibility.
REQ-027 out_pixel and out_last SHALL hold stable while out_valid is high and out_ready is low.
REQ-028 FSM states:
- FILL: accept inputs; no outputs until output 0 is eligible.
- RUN: one input is accepted for each output.
- FLUSH: after the last input, emit the remaining WIDTH+1 outputs with in_ready = 0.
- DONE: assert frame_done for one cycle, then return to FILL for the next frame.
REQ-029 In RUN, in_ready = !out_valid || out_ready, giving sustained throughput of one pixel per cycle.
REQ-030 In FILL, in_ready = 1 until output 0 is eligible.
REQ-031 Row and column counters SHALL wrap at WIDTH-1 and HEIGHT-1; the frame boundary is implied by the counters (there is no SOF input).
REQ-032 A new frame's first input SHALL NOT be accepted until frame_done has pulsed; in_ready = 0 in FLUSH and DONE.
REQ-033 When an output transfer and an input transfer occur in the same cycle, the output register SHALL load the next eligible result with no bubble.

Reset
REQ-034 While rst is high: out_valid = 0, out_pixel = 0, out_last = 0, frame_done = 0, in_ready = 0, FSM = FILL, counters = 0, and the latched kernel, shift and mode are cleared to 0.
REQ-035 Line-buffer contents are not reset; they SHALL NOT affect outputs after reset, because every interior window is fully refilled first.
REQ-036 Reset asserted mid-frame discards the partial frame; the first input accepted after rst falls is treated as row 0, col 0.
REQ-037 in_ready SHALL rise no earlier than the first clock edge after rst deasserts.

Verification
REQ-038 4x4 frame (WIDTH=HEIGHT=4), all pixels 100, SobelX kernel, mode 0, shift 0 -> 16 outputs, all 0, out_last on the 16th, one frame_done pulse.
REQ-039 256x256 frame, columns 0-127 = 0 and 128-255 = 255, SobelX, mode 0 -> interior cols 127 and 128 = 255, all other outputs 0, 65536 outputs.
REQ-040 Same image with negated SobelX: mode 0 -> all outputs 0; mode 1 -> cols 127 and 128 = 255.
REQ-041 Random out_ready at 30% duty with in_valid always high -> output stream bit-identical to a golden model; no drops or duplicates; outputs stable while stalled.
REQ-042 Reset pulsed after 1000 inputs, then a full frame -> output matches the golden model for that new frame only.
REQ-043 Two back-to-back 8x8 frames with different kernels -> each frame uses the kernel present at its own first pixel; two frame_done pulses.

Source files
------------

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster-order frame: two line buffers plus a 3x3
// window feed a single registered output stage with valid/ready handshakes on both sides.
module conv3x3_stream #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int BITW   = 8,
  parameter int ACCW   = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [71:0]     k_flat,
  input  logic [3:0]      shift,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITW-1:0] in_pixel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_pixel,
  output logic            out_last,
  output logic            frame_done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0]   COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0]   ROW_MAX = RW'(HEIGHT - 1);
  localparam logic [ACCW-1:0] SAT_MAX = ACCW'(255);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic [RW-1:0]   in_row_q, in_row_d, out_row_q, out_row_d;
  logic [CW-1:0]   in_col_q, in_col_d, out_col_q, out_col_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_pixel_q, out_pixel_d;
  logic            out_last_q, out_last_d;
  logic            frame_done_q, frame_done_d;
  logic [71:0]     k_q, k_d;
  logic [3:0]      shift_q, shift_d;
  logic            mode_q, mode_d;

  logic [BITW-1:0] lb0_q [WIDTH];
  logic [BITW-1:0] lb1_q [WIDTH];
  logic [BITW-1:0] win_q [3][3];
  logic [BITW-1:0] win_n [3][3];

  logic                   in_fire, out_xfer, produces, in_last_px;
  logic                   load_conv, load_flush, out_border;
  logic signed [ACCW-1:0] acc, res;
  logic [ACCW-1:0]        mag;
  logic [7:0]             sat;

  // New frames wait in FLUSH/DONE; armed_q keeps in_ready low until the first edge after reset.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_FILL:  in_ready = armed_q;
      S_RUN:   in_ready = !out_valid_q || out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_fire    = in_valid && in_ready;
  assign out_xfer   = out_valid_q && out_ready;
  assign in_last_px = (in_row_q == ROW_MAX) && (in_col_q == COL_MAX);
  // Accepting input index i completes the window for output i-WIDTH-1.
  assign produces   = (in_row_q >= RW'(2)) || ((in_row_q == RW'(1)) && (in_col_q != '0));
  assign out_border = (out_row_q == '0) || (out_row_q == ROW_MAX) ||
                      (out_col_q == '0) || (out_col_q == COL_MAX);

  // Window as it will look once the current pixel is shifted in; column 2 is the newest.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_n[i][0] = win_q[i][1];
      win_n[i][1] = win_q[i][2];
    end
    win_n[0][2] = lb1_q[in_col_q];
    win_n[1][2] = lb0_q[in_col_q];
    win_n[2][2] = in_pixel;
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = acc + ACCW'($signed(k_q[(i*3+j)*8 +: 8])) *
                    ACCW'($signed({1'b0, win_n[i][j]}));
      end
    end
    res = acc >>> shift_q;
    mag = res[ACCW-1] ? -res : res;
    if (mag > SAT_MAX)               sat = 8'hFF;
    else                             sat = mag[7:0];
    if (!mode_q && res[ACCW-1])      sat = 8'h00;
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d      = state_q;
    armed_d      = 1'b1;
    in_row_d     = in_row_q;
    in_col_d     = in_col_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_pixel_d  = out_pixel_q;
    out_last_d   = out_last_q && !out_xfer;
    frame_done_d = 1'b0;
    k_d          = k_q;
    shift_d      = shift_q;
    mode_d       = mode_q;

    load_conv  = in_fire && produces;
    load_flush = (state_q == S_FLUSH) && (!out_valid_q || out_ready) &&
                 ((out_row_q != '0) || (out_col_q != '0));

    if (in_fire) begin
      if (in_row_q == '0 && in_col_q == '0) begin
        k_d     = k_flat;
        shift_d = shift;
        mode_d  = mode;
      end
      if (in_col_q == COL_MAX) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_MAX) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end

    if (load_conv || load_flush) begin
      out_valid_d = 1'b1;
      out_pixel_d = out_border ? 8'h00 : sat;
      out_last_d  = (out_row_q == ROW_MAX) && (out_col_q == COL_MAX);
      if (out_col_q == COL_MAX) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_MAX) ? '0 : out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end

    case (state_q)
      S_FILL:  if (load_conv) state_d = S_RUN;
      S_RUN:   if (in_fire && in_last_px) state_d = S_FLUSH;
      S_FLUSH: if (out_xfer && out_last_q) begin
                 state_d      = S_DONE;
                 frame_done_d = 1'b1;
               end
      default: state_d = S_FILL;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; blocking ones here would race readers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      armed_q      <= 1'b0;
      in_row_q     <= '0;
      in_col_q     <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      k_q          <= '0;
      shift_q      <= '0;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      in_row_q     <= in_row_d;
      in_col_q     <= in_col_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      k_q          <= k_d;
      shift_q      <= shift_d;
      mode_q       <= mode_d;
    end
  end

  // NOTE: storage arrays carry no reset; every interior window is refilled before it is used.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      lb0_q[in_col_q] <= in_pixel;
      lb1_q[in_col_q] <= lb0_q[in_col_q];
      win_q           <= win_n;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule
